// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
// The state enum and fixed byte values live here so the bench can use them too.
package spi_reg_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam int CMD_READ_BIT = 7;

    localparam logic [DATA_W-1:0] TX_IDLE      = 8'h00;
    localparam logic [DATA_W-1:0] TX_NOT_READY = 8'hFF;
    localparam logic [DATA_W-1:0] TO_RDATA     = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_WBUS,
        ST_RBUS,
        ST_RDATA,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Simple request/acknowledge register bus between the controller and the register file.
interface spi_reg_ctrl_if;
    import spi_reg_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/spi_bus_timer.sv
// Wait counter for an outstanding bus request; expired pulses TIMEOUT cycles after start.
// A TIMEOUT of 0 never expires.
module spi_bus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;

    assign expired = (TIMEOUT != 0) && armed_q && (cnt_q == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (start) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else if (clear || expired) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (armed_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Turns the SPI slave byte stream into register-bus writes and prefetched reads.
// One frame = command byte (R/W + start address) followed by auto-incrementing data bytes.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ssel,
    input  logic              byteReceived,
    input  logic [DATA_W-1:0] receivedData,
    input  logic              dataNeeded,
    output logic [DATA_W-1:0] dataToSend,
    spi_reg_ctrl_if.master    bus,
    output logic              frame_done,
    output logic              err_overrun,
    output logic              err_timeout,
    input  logic              err_clr
);

    state_t            state_q, state_d;
    logic              ssel_meta, ssel_sync;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              fd_q, fd_d;
    logic              ovr_q, ovr_d;
    logic              to_q, to_d;
    logic              expired;
    logic              done;
    logic [DATA_W-1:0] rd_result;

    // dataNeeded is observed only; tx_q is always kept ready for the slave.
    logic unused_data_needed;
    assign unused_data_needed = dataNeeded;

    assign done      = req_q && (bus.ack || expired);
    assign rd_result = bus.ack ? bus.rdata : TO_RDATA;

    spi_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (req_d && !req_q),
        .clear   (req_q && !req_d),
        .expired (expired)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        req_d   = req_q;
        we_d    = we_q;
        baddr_d = baddr_q;
        wdata_d = wdata_q;
        fd_d    = 1'b0;
        ovr_d   = err_clr ? 1'b0 : ovr_q;
        to_d    = err_clr ? 1'b0 : to_q;

        if (done) begin
            req_d = 1'b0;
            if (!bus.ack) to_d = 1'b1;
        end
        if ((state_q == ST_WBUS || state_q == ST_RBUS) && byteReceived) ovr_d = 1'b1;

        case (state_q)
            ST_IDLE: if (!ssel_sync) state_d = ST_CMD;
            ST_CMD: begin
                if (ssel_sync) begin
                    state_d = ST_IDLE;
                    fd_d    = 1'b1;
                end else if (byteReceived) begin
                    addr_d = receivedData[ADDR_W-1:0];
                    if (receivedData[CMD_READ_BIT]) begin
                        state_d = ST_RBUS;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        baddr_d = receivedData[ADDR_W-1:0];
                        tx_d    = TX_NOT_READY;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (ssel_sync) begin
                    state_d = ST_IDLE;
                    fd_d    = 1'b1;
                end else if (byteReceived) begin
                    state_d = ST_WBUS;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    baddr_d = addr_q;
                    wdata_d = receivedData;
                end
            end
            ST_WBUS: begin
                if (done) begin
                    addr_d  = addr_q + 7'd1;
                    state_d = ssel_sync ? ST_IDLE : ST_WDATA;
                    fd_d    = ssel_sync;
                end else if (ssel_sync) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RBUS: begin
                if (done) begin
                    state_d = ssel_sync ? ST_IDLE : ST_RDATA;
                    fd_d    = ssel_sync;
                    tx_d    = rd_result;
                end else if (ssel_sync) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RDATA: begin
                if (ssel_sync) begin
                    state_d = ST_IDLE;
                    fd_d    = 1'b1;
                end else if (byteReceived) begin
                    state_d = ST_RBUS;
                    addr_d  = addr_q + 7'd1;
                    baddr_d = addr_q + 7'd1;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    tx_d    = TX_NOT_READY;
                end
            end
            ST_DRAIN: begin
                if (done) begin
                    state_d = ST_IDLE;
                    fd_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Whatever brought us back to IDLE, the slave shifts out zeros until the next read.
        if (state_d == ST_IDLE) tx_d = TX_IDLE;
    end

    // ssel resets to its inactive (high) level so reset release never looks like a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssel_meta <= 1'b1;
            ssel_sync <= 1'b1;
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            tx_q      <= TX_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            baddr_q   <= '0;
            wdata_q   <= '0;
            fd_q      <= 1'b0;
            ovr_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            ssel_meta <= ssel;
            ssel_sync <= ssel_meta;
            state_q   <= state_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            req_q     <= req_d;
            we_q      <= we_d;
            baddr_q   <= baddr_d;
            wdata_q   <= wdata_d;
            fd_q      <= fd_d;
            ovr_q     <= ovr_d;
            to_q      <= to_d;
        end
    end

    assign dataToSend  = tx_q;
    assign bus.req     = req_q;
    assign bus.we      = we_q;
    assign bus.addr    = baddr_q;
    assign bus.wdata   = wdata_q;
    assign frame_done  = fd_q;
    assign err_overrun = ovr_q;
    assign err_timeout = to_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: a register-file responder on the bus, a scoreboard of expected
// bus requests, table-driven write/read frames and hand-written corner-case sequences.
module tb_spi_reg_ctrl;
    import spi_reg_pkg::*;

    localparam int TO_CYCLES = 8;

    typedef struct {
        logic       we;
        logic [6:0] addr;
        logic [7:0] wdata;
    } bus_txn_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0, d1;
        logic [6:0] a0, a1;
    } wr_vec_t;

    typedef struct {
        logic [7:0] cmd;
        logic [6:0] a0, a1, a2;
        logic [7:0] q0, q1;
    } rd_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ssel;
    logic       byteReceived;
    logic [7:0] receivedData;
    logic       dataNeeded;
    logic [7:0] dataToSend;
    logic       frame_done;
    logic       err_overrun;
    logic       err_timeout;
    logic       err_clr;

    spi_reg_ctrl_if bus ();

    spi_reg_ctrl #(.TIMEOUT(TO_CYCLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .ssel         (ssel),
        .byteReceived (byteReceived),
        .receivedData (receivedData),
        .dataNeeded   (dataNeeded),
        .dataToSend   (dataToSend),
        .bus          (bus),
        .frame_done   (frame_done),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    bus_txn_t   sb_q[$];
    logic [7:0] mem [0:127];
    int         n_checks = 0;
    int         n_fail = 0;
    int         fd_count = 0;
    bit         ack_en = 1'b1;
    int         ack_lat = 1;
    int         wait_cnt = 0;
    logic       prev_req = 1'b0;
    wr_vec_t    wr_tab[4];
    rd_vec_t    rd_tab[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register-file responder: acks ack_lat cycles after a request is seen.
    initial begin : responder
        bus.ack   = 1'b0;
        bus.rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.ack = 1'b0;
            if (!bus.req || rst) begin
                wait_cnt = 0;
            end else if (ack_en) begin
                wait_cnt++;
                if (wait_cnt >= ack_lat) begin
                    wait_cnt = 0;
                    bus.ack  = 1'b1;
                    if (bus.we) mem[bus.addr] = bus.wdata;
                    else        bus.rdata     = mem[bus.addr];
                end
            end
        end
    end

    // Scoreboard: each new request is popped against the queued expectation.
    initial begin : monitor
        bus_txn_t exp_t;
        forever begin
            @(negedge clk);
            if (frame_done) fd_count++;
            if (!rst && bus.req && !prev_req) begin
                check("sb_request_expected", sb_q.size() > 0, 1'b1);
                if (sb_q.size() > 0) begin
                    exp_t = sb_q.pop_front();
                    check("bus_we", bus.we, exp_t.we);
                    check("bus_addr", bus.addr, exp_t.addr);
                    if (exp_t.we) check("bus_wdata", bus.wdata, exp_t.wdata);
                end
            end
            prev_req = rst ? 1'b0 : bus.req;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        byteReceived = 1'b1;
        receivedData = b;
        @(negedge clk);
        byteReceived = 1'b0;
        receivedData = 8'h00;
    endtask

    task automatic expect_txn(input logic we, input logic [6:0] a, input logic [7:0] d);
        bus_txn_t t;
        t.we    = we;
        t.addr  = a;
        t.wdata = d;
        sb_q.push_back(t);
    endtask

    task automatic start_frame();
        ssel = 1'b0;
        tick(4);
    endtask

    task automatic end_frame();
        int start_cnt;
        int n;
        start_cnt = fd_count;
        n = 0;
        ssel = 1'b1;
        while (fd_count == start_cnt && n < 40) begin
            @(negedge clk);
            n++;
        end
        tick(4);
        check("frame_done_pulses", fd_count - start_cnt, 1);
        check("frame_end_req_low", bus.req, 1'b0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin : main
        int n;
        wr_tab[0] = '{8'h05, 8'hAA, 8'hBB, 7'h05, 7'h06};
        wr_tab[1] = '{8'h7F, 8'h12, 8'h34, 7'h7F, 7'h00};
        wr_tab[2] = '{8'h40, 8'h00, 8'hFF, 7'h40, 7'h41};
        wr_tab[3] = '{8'h00, 8'h5A, 8'hA5, 7'h00, 7'h01};
        rd_tab[0] = '{8'h90, 7'h10, 7'h11, 7'h12, 8'h11, 8'h22};
        rd_tab[1] = '{8'h85, 7'h05, 7'h06, 7'h07, 8'hAA, 8'hBB};
        rd_tab[2] = '{8'hFF, 7'h7F, 7'h00, 7'h01, 8'h12, 8'h5A};

        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h10] = 8'h11;
        mem[7'h11] = 8'h22;

        rst = 1'b1; ssel = 1'b1; byteReceived = 1'b0; receivedData = 8'h00;
        dataNeeded = 1'b0; err_clr = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("reset_tx", dataToSend, TX_IDLE);
        check("reset_req", bus.req, 1'b0);
        check("reset_we", bus.we, 1'b0);
        check("reset_addr", bus.addr, 7'h00);
        check("reset_wdata", bus.wdata, 8'h00);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_err_overrun", err_overrun, 1'b0);
        check("reset_err_timeout", err_timeout, 1'b0);

        // Write frames, including the 0x7F -> 0x00 wrap.
        ack_lat = 1;
        for (int i = 0; i < 4; i++) begin
            start_frame();
            send_byte(wr_tab[i].cmd);
            tick(6);
            check("wr_cmd_no_req", bus.req, 1'b0);
            expect_txn(1'b1, wr_tab[i].a0, wr_tab[i].d0);
            send_byte(wr_tab[i].d0);
            check("wr_req_latency", bus.req, 1'b1);
            tick(8);
            expect_txn(1'b1, wr_tab[i].a1, wr_tab[i].d1);
            send_byte(wr_tab[i].d1);
            tick(8);
            check("wr_tx_idle", dataToSend, TX_IDLE);
            end_frame();
            check("wr_mem0", mem[wr_tab[i].a0], wr_tab[i].d0);
            check("wr_mem1", mem[wr_tab[i].a1], wr_tab[i].d1);
        end

        // Read frames with prefetch; the last prefetch is still in flight as ssel rises.
        ack_lat = 3;
        for (int i = 0; i < 3; i++) begin
            start_frame();
            check("rd_tx_cmd", dataToSend, TX_IDLE);
            expect_txn(1'b0, rd_tab[i].a0, 8'h00);
            send_byte(rd_tab[i].cmd);
            check("rd_tx_not_ready", dataToSend, TX_NOT_READY);
            tick(10);
            check("rd_tx_byte0", dataToSend, rd_tab[i].q0);
            expect_txn(1'b0, rd_tab[i].a1, 8'h00);
            send_byte(8'hC3);
            tick(10);
            check("rd_tx_byte1", dataToSend, rd_tab[i].q1);
            expect_txn(1'b0, rd_tab[i].a2, 8'h00);
            send_byte(8'h3C);
            end_frame();
            check("rd_tx_after_frame", dataToSend, TX_IDLE);
        end
        check("rd_no_overrun", err_overrun, 1'b0);
        check("rd_no_timeout", err_timeout, 1'b0);

        // Overrun: second byte lands while the first write is outstanding.
        ack_lat = 6;
        start_frame();
        send_byte(8'h30);
        tick(4);
        expect_txn(1'b1, 7'h30, 8'h01);
        send_byte(8'h01);
        tick(2);
        send_byte(8'h02);
        check("ovr_flag_set", err_overrun, 1'b1);
        tick(10);
        expect_txn(1'b1, 7'h31, 8'h03);
        send_byte(8'h03);
        tick(10);
        end_frame();
        check("ovr_mem_first", mem[7'h30], 8'h01);
        check("ovr_mem_next", mem[7'h31], 8'h03);
        check("ovr_no_timeout", err_timeout, 1'b0);
        check("ovr_flag_sticky", err_overrun, 1'b1);
        pulse_err_clr();
        check("ovr_flag_cleared", err_overrun, 1'b0);

        // Timeout: no ack for a read, then a drained prefetch once acks resume.
        ack_en = 1'b0;
        start_frame();
        expect_txn(1'b0, 7'h20, 8'h00);
        send_byte(8'hA0);
        n = 0;
        while (bus.req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to_req_cycles", n, TO_CYCLES);
        check("to_flag_set", err_timeout, 1'b1);
        check("to_tx_ff", dataToSend, TO_RDATA);
        check("to_no_overrun", err_overrun, 1'b0);
        pulse_err_clr();
        check("to_flag_cleared", err_timeout, 1'b0);
        ack_en = 1'b1;
        ack_lat = 6;
        expect_txn(1'b0, 7'h21, 8'h00);
        send_byte(8'h00);
        check("drain_tx_not_ready", dataToSend, TX_NOT_READY);
        end_frame();
        check("drain_no_timeout", err_timeout, 1'b0);

        // Reset while a write is outstanding, then a normal frame.
        ack_en = 1'b0;
        start_frame();
        send_byte(8'h50);
        tick(3);
        expect_txn(1'b1, 7'h50, 8'h77);
        send_byte(8'h77);
        tick(2);
        check("rst_pre_req", bus.req, 1'b1);
        #2;
        rst = 1'b1;
        ssel = 1'b1;
        #1;
        check("rst_async_req", bus.req, 1'b0);
        check("rst_async_we", bus.we, 1'b0);
        check("rst_async_addr", bus.addr, 7'h00);
        check("rst_async_wdata", bus.wdata, 8'h00);
        check("rst_async_tx", dataToSend, TX_IDLE);
        check("rst_async_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        ack_en = 1'b1;
        ack_lat = 1;
        start_frame();
        send_byte(8'h51);
        tick(4);
        expect_txn(1'b1, 7'h51, 8'h99);
        send_byte(8'h99);
        tick(6);
        end_frame();
        check("rst_next_frame_mem", mem[7'h51], 8'h99);
        check("rst_aborted_not_written", mem[7'h50], 8'h00);

        tick(4);
        check("sb_all_consumed", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-access controller that sits behind `SPI_slave`. It turns the slave's byte stream into register-bus transactions. Each SPI frame (ssel low) carries one command byte (R/W flag plus start address) followed by any number of data bytes, with the address auto-incrementing. The block issues bus writes for received bytes and prefetches bus reads so that the slave always has `dataToSend` ready.

## Interface
Parameters:
- `TIMEOUT`, default 255: clk cycles to wait for `bus_ack` before abandoning a request. 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `ssel`  in  1  SPI chip select, active low, same signal as the one fed to `SPI_slave`. Synchronized internally with 2 flops.
- `byteReceived`  in  1  one-cycle pulse from the slave.
- `receivedData`  in  8  byte from the slave, valid with `byteReceived`.
- `dataNeeded`  in  1  slave is sampling `dataToSend`; observed only.
- `dataToSend`  out  8  next byte to shift out; driven by register `tx_q`.
- `bus_req`  out  1  bus request; held high until `bus_ack` or timeout.
- `bus_we`  out  1  1 = write, 0 = read; stable while `bus_req` is high.
- `bus_addr`  out  7  register address.
- `bus_wdata`  out  8  write data.
- `bus_rdata`  in  8  read data; valid with `bus_ack`.
- `bus_ack`  in  1  one-cycle completion pulse.
- `frame_done`  out  1  one-cycle pulse when a frame ends and the block returns to IDLE.
- `err_overrun`  out  1  sticky; a byte arrived while a bus request was outstanding.
- `err_timeout`  out  1  sticky; a request timed out.
- `err_clr`  in  1  clears both sticky flags. If an error event occurs in the same cycle, the event wins.

## Operation
- Command byte: bit7 = 1 selects read, 0 selects write. Bits 6:0 are the start address.
- The address counter `addr_q` increments by 1 after every data byte and wraps 0x7F → 0x00.
- FSM states:
  - IDLE: ssel high.
  - CMD: await the command byte.
  - WDATA: await a write byte.
  - WBUS: write request outstanding.
  - RBUS: read request outstanding.
  - RDATA: read data loaded into `tx_q`; await the byte exchange.
  - DRAIN: ssel rose while a request was still outstanding.
- Transitions:
  - IDLE → CMD on synchronized ssel falling.
  - CMD + `byteReceived`:
    - write command → WDATA.
    - read command → RBUS with `bus_addr` = cmd[6:0].
  - WDATA + `byteReceived` → WBUS with `bus_wdata` = byte and `bus_addr` = `addr_q`.
  - WBUS + `bus_ack` → WDATA, `addr_q` + 1.
  - RBUS + `bus_ack` → RDATA, `tx_q` ← `bus_rdata`.
  - RDATA + `byteReceived` → RBUS at `addr_q` + 1. The byte the master sent is ignored.
  - Any state with synchronized ssel high:
    - `bus_req` low → IDLE, with a `frame_done` pulse.
    - `bus_req` high → DRAIN. The request is completed (or times out) and its result discarded; then IDLE with `frame_done`.
- Overrun: `byteReceived` in WBUS or RBUS sets `err_overrun`. The byte is dropped, and the state and address are unchanged.
- Timeout: a wait counter runs while `bus_req` is high. When it reaches `TIMEOUT`, the block drops `bus_req` and sets `err_timeout`, then continues as if acked:
  - `bus_rdata` is replaced by 0xFF.
  - The address still increments.
- `tx_q` values:
  - 0x00 in IDLE, CMD and the whole of a write frame.
  - 0xFF while in RBUS (data not ready).
  - Read data in RDATA.

## Timing
- Reset values: state = IDLE, `tx_q` = 0x00, `bus_req` = 0, `bus_we` = 0, `bus_addr` = 0, `bus_wdata` = 0, `frame_done` = 0, both error flags 0, `addr_q` = 0.
- `bus_req` rises on the clk edge following `byteReceived` (1-cycle latency).
- `tx_q` updates on the edge following `bus_ack`.
- `bus_req` falls on the edge following `bus_ack`. `bus_ack` must not be asserted while `bus_req` is low; if it is, it is ignored.
- ssel uses 2-flop sync: IDLE↔CMD entry and exit lag ssel by 2–3 cycles.
- System requirement: one SCK period must be at least bus latency + 4 clk. Otherwise read bytes are sent as 0xFF or an overrun is flagged; both are legal, defined outcomes.
- Simultaneous `bus_ack` and ssel rise: the ack completes the transaction (for writes, the write has already occurred), then IDLE.
- Reset mid-transaction: `bus_req` drops immediately (asynchronously). The bus must tolerate an aborted request.

## Structure
- Package `spi_reg_pkg` holds:
  - the state enum;
  - `CMD_READ_BIT` = 7;
  - `TX_IDLE` = 8'h00;
  - `TX_NOT_READY` = 8'hFF;
  - `TO_RDATA` = 8'hFF.
- Sub-module `spi_bus_timer`: wait counter with `start`/`clear`/`expired`, parameterized by `TIMEOUT`.
- Top level is the FSM, address counter and output registers. Instantiation alongside `SPI_slave` happens at the chip top, not inside this block.

## Test plan
- Write burst: frame 0x05, 0xAA, 0xBB → bus writes (0x05, 0xAA) then (0x06, 0xBB); `frame_done` pulses once.
- Read burst: frame 0x90 plus 2 dummy bytes, bus returns 0x11 @0x10 and 0x22 @0x11 with 3-cycle latency → MISO bytes 0x00, 0x11, 0x22; a third prefetch is issued at 0x12 and drained after ssel rises.
- Wrap-around: write command 0x7F, 2 bytes → addresses 0x7F then 0x00.
- Timeout with `TIMEOUT` = 8: read at 0x20 with no ack → `bus_req` drops after 8 cycles, `err_timeout` = 1, next MISO byte 0xFF; `err_clr` clears the flag.
- Overrun: ack delayed beyond the next `byteReceived` in a write frame → `err_overrun` = 1, the second byte is never written, the address does not advance.
- Reset mid-WBUS: assert `rst` while `bus_req` is high → `bus_req` goes low in the same cycle, all outputs return to reset values, and the next frame works normally.
